load_scoreboard_hazard_unit: RTL and testbench

- Parametrised successor to the single-cycle load-use detector. Stalls fetch/decode for loads whose data becomes forwardable LOAD_LATENCY cycles after EX; a per-register countdown scoreboard enables multi-cycle stalls.
- Sits in ID beside the control unit. Drives PC write-enable, IF/ID write-enable and the ID/EX control-bubble mux.
- LOAD_LATENCY=1 reproduces classic one-bubble load-use behaviour exactly.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/reg_scoreboard.sv | 46 ++++
 rtl/load_scoreboard_hazard_unit.sv | 83 ++++++++
 tb/tb_load_scoreboard_hazard_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the load hazard unit: default register index width,
// the hardwired-zero register index and the counter-width helper.
package hazard_pkg;

    localparam int DEFAULT_REG_ADDR_W = 5;
    localparam int REG_X0             = 0;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register countdown scoreboard: a load allocates its destination, a
// younger ALU write clears it, every live entry counts down once per cycle.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = DEFAULT_REG_ADDR_W,
    parameter int LOAD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_alloc,
    input  logic                  i_clear,
    input  logic [REG_ADDR_W-1:0] i_wr_addr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_a,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_b,
    output logic                  o_pending_a,
    output logic                  o_pending_b
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int CNT_W    = (clog2(LOAD_LATENCY + 1) < 1) ? 1 : clog2(LOAD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(LOAD_LATENCY - 1);

    logic [CNT_W-1:0] r_cnt [NUM_REGS];

    // Allocation wins over clear, which wins over the free-running decrement.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!arst_n) begin
                r_cnt[i] <= '0;
            end else if (i_alloc && (i_wr_addr == REG_ADDR_W'(i))) begin
                r_cnt[i] <= CNT_ALLOC;
            end else if (i_clear && (i_wr_addr == REG_ADDR_W'(i))) begin
                r_cnt[i] <= '0;
            end else if (r_cnt[i] != '0) begin
                r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end else begin
                r_cnt[i] <= r_cnt[i];
            end
        end
    end

    assign o_pending_a = (r_cnt[i_rd_addr_a] != '0);
    assign o_pending_b = (r_cnt[i_rd_addr_b] != '0);

endmodule

// File: rtl/load_scoreboard_hazard_unit.sv
// Load-use hazard unit for ID: stalls fetch/decode until a load result in
// flight becomes forwardable, and counts stall cycles.
module load_scoreboard_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = DEFAULT_REG_ADDR_W,
    parameter int LOAD_LATENCY = 1,
    parameter int STALL_CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [REG_ADDR_W-1:0]  IF_ID_Rs1,
    input  logic [REG_ADDR_W-1:0]  IF_ID_Rs2,
    input  logic                   IF_ID_uses_rs1,
    input  logic                   IF_ID_uses_rs2,
    input  logic [REG_ADDR_W-1:0]  ID_EX_Rd,
    input  logic                   ID_EX_mem_read,
    input  logic                   ID_EX_reg_write,
    input  logic                   ID_EX_valid,
    input  logic                   flush,
    output logic                   PC_write,
    output logic                   IF_ID_write,
    output logic                   control_write,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [REG_ADDR_W-1:0] X0_ADDR = REG_ADDR_W'(REG_X0);

    logic w_load_ex;
    logic w_alu_ex;
    logic w_pending_rs1;
    logic w_pending_rs2;
    logic w_hazard_rs1;
    logic w_hazard_rs2;
    logic w_stall;
    logic w_write_en;
    logic [STALL_CNT_W-1:0] r_stall_count;

    reg_scoreboard #(
        .REG_ADDR_W   (REG_ADDR_W),
        .LOAD_LATENCY (LOAD_LATENCY)
    ) u_scoreboard (
        .clk         (clk),
        .arst_n      (arst_n),
        .i_alloc     (w_load_ex),
        .i_clear     (w_alu_ex),
        .i_wr_addr   (ID_EX_Rd),
        .i_rd_addr_a (IF_ID_Rs1),
        .i_rd_addr_b (IF_ID_Rs2),
        .o_pending_a (w_pending_rs1),
        .o_pending_b (w_pending_rs2)
    );

    // Classify EX and detect same-cycle or scoreboarded dependences; flush only masks the stall.
    always_comb begin
        w_load_ex    = ID_EX_valid & ID_EX_mem_read & ID_EX_reg_write & (ID_EX_Rd != X0_ADDR);
        w_alu_ex     = ID_EX_valid & ~ID_EX_mem_read & ID_EX_reg_write & (ID_EX_Rd != X0_ADDR);
        w_hazard_rs1 = IF_ID_uses_rs1 & (IF_ID_Rs1 != X0_ADDR)
                     & ((w_load_ex & (ID_EX_Rd == IF_ID_Rs1)) | w_pending_rs1);
        w_hazard_rs2 = IF_ID_uses_rs2 & (IF_ID_Rs2 != X0_ADDR)
                     & ((w_load_ex & (ID_EX_Rd == IF_ID_Rs2)) | w_pending_rs2);
        w_stall      = ~flush & (w_hazard_rs1 | w_hazard_rs2);
        // Reset low releases any stall immediately, even before the clearing edge.
        w_write_en   = ~(w_stall & arst_n);
    end

    // Saturating count of stall cycles.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {STALL_CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + STALL_CNT_W'(1);
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

    assign PC_write      = w_write_en;
    assign IF_ID_write   = w_write_en;
    assign control_write = w_write_en;
    assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_load_scoreboard_hazard_unit.sv
// Scoreboard bench for load_scoreboard_hazard_unit: five instances with
// different latencies/counter widths share stimulus; each vector checks one.
module tb_load_scoreboard_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst_n = 1'b0;
    logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
    logic       u1 = 1'b0, u2 = 1'b0, mr = 1'b0, rw = 1'b0, v = 1'b0, fl = 1'b0;

    logic        pc_w [5];
    logic        ifid_w [5];
    logic        ctl_w [5];
    logic [31:0] sc0, sc1, sc2, sc3;
    logic [1:0]  sc4;

    load_scoreboard_hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .STALL_CNT_W(32)) u_ll1 (
        .clk(clk), .arst_n(arst_n), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_uses_rs1(u1),
        .IF_ID_uses_rs2(u2), .ID_EX_Rd(rd), .ID_EX_mem_read(mr), .ID_EX_reg_write(rw),
        .ID_EX_valid(v), .flush(fl), .PC_write(pc_w[0]), .IF_ID_write(ifid_w[0]),
        .control_write(ctl_w[0]), .stall_count(sc0));
    load_scoreboard_hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(2), .STALL_CNT_W(32)) u_ll2 (
        .clk(clk), .arst_n(arst_n), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_uses_rs1(u1),
        .IF_ID_uses_rs2(u2), .ID_EX_Rd(rd), .ID_EX_mem_read(mr), .ID_EX_reg_write(rw),
        .ID_EX_valid(v), .flush(fl), .PC_write(pc_w[1]), .IF_ID_write(ifid_w[1]),
        .control_write(ctl_w[1]), .stall_count(sc1));
    load_scoreboard_hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .STALL_CNT_W(32)) u_ll3 (
        .clk(clk), .arst_n(arst_n), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_uses_rs1(u1),
        .IF_ID_uses_rs2(u2), .ID_EX_Rd(rd), .ID_EX_mem_read(mr), .ID_EX_reg_write(rw),
        .ID_EX_valid(v), .flush(fl), .PC_write(pc_w[2]), .IF_ID_write(ifid_w[2]),
        .control_write(ctl_w[2]), .stall_count(sc2));
    load_scoreboard_hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(4), .STALL_CNT_W(32)) u_ll4 (
        .clk(clk), .arst_n(arst_n), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_uses_rs1(u1),
        .IF_ID_uses_rs2(u2), .ID_EX_Rd(rd), .ID_EX_mem_read(mr), .ID_EX_reg_write(rw),
        .ID_EX_valid(v), .flush(fl), .PC_write(pc_w[3]), .IF_ID_write(ifid_w[3]),
        .control_write(ctl_w[3]), .stall_count(sc3));
    load_scoreboard_hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .STALL_CNT_W(2)) u_sat (
        .clk(clk), .arst_n(arst_n), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_uses_rs1(u1),
        .IF_ID_uses_rs2(u2), .ID_EX_Rd(rd), .ID_EX_mem_read(mr), .ID_EX_reg_write(rw),
        .ID_EX_valid(v), .flush(fl), .PC_write(pc_w[4]), .IF_ID_write(ifid_w[4]),
        .control_write(ctl_w[4]), .stall_count(sc4));

    typedef struct {
        int    sel;
        string name;
        logic  wr;
        int    cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam int EX_BUB = 0, EX_LOAD = 1, EX_ALU = 2, EX_DEADLOAD = 3;

    function automatic logic [2:0] get_w(input int sel);
        case (sel)
            0: get_w = {pc_w[0], ifid_w[0], ctl_w[0]};
            1: get_w = {pc_w[1], ifid_w[1], ctl_w[1]};
            2: get_w = {pc_w[2], ifid_w[2], ctl_w[2]};
            3: get_w = {pc_w[3], ifid_w[3], ctl_w[3]};
            default: get_w = {pc_w[4], ifid_w[4], ctl_w[4]};
        endcase
    endfunction

    function automatic logic [31:0] get_c(input int sel);
        case (sel)
            0: get_c = sc0;
            1: get_c = sc1;
            2: get_c = sc2;
            3: get_c = sc3;
            default: get_c = {30'd0, sc4};
        endcase
    endfunction

    // Drive one cycle of inputs and queue the expected outputs for that cycle.
    task automatic step(input int sel, input string name, input logic rst,
                        input int ex, input logic [4:0] a_rd,
                        input logic [4:0] a_rs1, input logic a_u1,
                        input logic [4:0] a_rs2, input logic a_u2,
                        input logic a_fl, input logic e_wr, input int e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        arst_n = rst;
        rd  = a_rd;
        v   = (ex != EX_BUB) && (ex != EX_DEADLOAD);
        mr  = (ex == EX_LOAD) || (ex == EX_DEADLOAD);
        rw  = (ex != EX_BUB);
        rs1 = a_rs1; u1 = a_u1;
        rs2 = a_rs2; u2 = a_u2;
        fl  = a_fl;
        e.sel = sel; e.name = name; e.wr = e_wr; e.cnt = e_cnt;
        q.push_back(e);
    endtask

    task automatic do_reset(input int sel, input int first_cnt);
        step(sel, "rst_a", 1'b0, EX_BUB, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, first_cnt);
        step(sel, "rst_b", 1'b0, EX_BUB, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 0);
    endtask

    // Monitor: the outputs are combinational, so every driven cycle presents a response.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [2:0]  act_w;
            logic [31:0] act_c;
            e     = q.pop_front();
            act_w = get_w(e.sel);
            act_c = get_c(e.sel);
            n_cmp = n_cmp + 1;
            if (act_w !== {3{e.wr}}) begin
                n_bad = n_bad + 1;
                $display("FAIL %s[dut%0d] writes: got %b expected %b", e.name, e.sel, act_w, {3{e.wr}});
            end
            if (e.cnt >= 0) begin
                n_cmp = n_cmp + 1;
                if (act_c !== 32'(e.cnt)) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s[dut%0d] stall_count: got %0d expected %0d", e.name, e.sel, act_c, e.cnt);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(0, -1);

        // LOAD_LATENCY=1: one bubble on Rs1, then one on Rs2
        step(0, "ll1_stall",  1'b1, EX_LOAD, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 0);
        step(0, "ll1_free",   1'b1, EX_BUB,  5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1);
        step(0, "ll1_next",   1'b1, EX_ALU,  5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1);
        step(0, "ll1_rs2",    1'b1, EX_LOAD, 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1);
        step(0, "ll1_rs2_ok", 1'b1, EX_BUB,  5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 2);

        // LOAD_LATENCY=3: exactly three stall cycles
        do_reset(2, -1);
        step(2, "ll3_s1",  1'b1, EX_LOAD, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 0);
        step(2, "ll3_s2",  1'b1, EX_BUB,  5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1);
        step(2, "ll3_s3",  1'b1, EX_BUB,  5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2);
        step(2, "ll3_go",  1'b1, EX_BUB,  5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 3);
        step(2, "ll3_end", 1'b1, EX_ALU,  5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 3);

        // WAW: younger ALU write to x7 clears the pending load
        do_reset(2, -1);
        step(2, "waw_nouse", 1'b1, EX_LOAD, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1, 0);
        step(2, "waw_alu",   1'b1, EX_ALU,  5'd7, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 0);
        step(2, "waw_use",   1'b1, EX_ALU,  5'd4, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 0);
        step(2, "waw_use2",  1'b1, EX_BUB,  5'd0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 0);

        // x0 and bubble loads never hazard or allocate
        step(2, "x0_load",  1'b1, EX_LOAD,     5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 0);
        step(2, "x0_after", 1'b1, EX_BUB,      5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 0);
        step(2, "bub_load", 1'b1, EX_DEADLOAD, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 0);
        step(2, "bub_next", 1'b1, EX_BUB,      5'd0, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 0);

        // LOAD_LATENCY=2: flush masks the stall but the load still allocates
        do_reset(1, -1);
        step(1, "fl_mask",  1'b1, EX_LOAD, 5'd10, 5'd10, 1'b1, 5'd0,  1'b0, 1'b1, 1'b1, 0);
        step(1, "fl_later", 1'b1, EX_BUB,  5'd0,  5'd0,  1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 0);
        step(1, "fl_free",  1'b1, EX_BUB,  5'd0,  5'd0,  1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 1);

        // Both sources hazard: one stall lasting the longer remaining count
        do_reset(2, -1);
        step(2, "dual_a", 1'b1, EX_LOAD, 5'd11, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 0);
        step(2, "dual_b", 1'b1, EX_LOAD, 5'd12, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 0);
        step(2, "dual_c", 1'b1, EX_BUB,  5'd0,  5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1);
        step(2, "dual_d", 1'b1, EX_BUB,  5'd0,  5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 2);
        step(2, "dual_e", 1'b1, EX_BUB,  5'd0,  5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 3);

        // LOAD_LATENCY=4: reset during the second stall cycle
        do_reset(3, -1);
        step(3, "mr_s1",   1'b1, EX_LOAD, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 0);
        step(3, "mr_rst",  1'b0, EX_BUB,  5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1);
        step(3, "mr_post", 1'b1, EX_BUB,  5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 0);
        step(3, "mr_hold", 1'b1, EX_BUB,  5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 0);

        // 2-bit stall counter saturates at 3
        do_reset(4, -1);
        for (int i = 0; i < 5; i++) begin
            step(4, "sat_stall", 1'b1, EX_LOAD, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, (i > 3) ? 3 : i);
        end
        step(4, "sat_idle", 1'b1, EX_BUB, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 3);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
